// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state type and byte-lane shift amounts used by the lane helper.
package lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Bit offset of each byte / half-word lane inside a 32-bit word
  localparam int LANE_B0 = 0;
  localparam int LANE_B1 = 8;
  localparam int LANE_B2 = 16;
  localparam int LANE_B3 = 24;
  localparam int LANE_H0 = 0;
  localparam int LANE_H1 = 16;

  // Bit offset of the addressed lane. Halves select on addr[1] only, so a
  // half at an odd address lands on the lane containing it.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] lo);
    logic [4:0] sh;
    sh = 5'(LANE_B0);
    case (size)
      SZ_BYTE: begin
        case (lo)
          2'd0:    sh = 5'(LANE_B0);
          2'd1:    sh = 5'(LANE_B1);
          2'd2:    sh = 5'(LANE_B2);
          default: sh = 5'(LANE_B3);
        endcase
      end
      SZ_HALF: sh = lo[1] ? 5'(LANE_H1) : 5'(LANE_H0);
      default: sh = 5'(LANE_B0);
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane helper for the load/store unit: extracts and sign/zero-extends the
// addressed lane of a memory word for loads, and splices store data into
// the old word for sub-word read-modify-write. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_store_data,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merged_word
);

  logic [4:0]  w_shift;
  logic [31:0] w_lane;
  logic [31:0] w_mask;
  logic        w_sign;

  // Move the addressed lane down to bit 0 and pick its width mask
  always_comb begin
    w_shift = lane_shift(i_size, i_addr_lo);
    w_lane  = i_old_word >> w_shift;
    w_mask  = '0;
    case (i_size)
      SZ_BYTE: w_mask = 32'h0000_00FF;
      SZ_HALF: w_mask = 32'h0000_FFFF;
      SZ_WORD: w_mask = 32'hFFFF_FFFF;
      default: w_mask = '0;
    endcase
  end

  // Load path: extend the right-aligned lane to a full word
  always_comb begin
    w_sign      = 1'b0;
    o_load_data = '0;
    case (i_size)
      SZ_BYTE: begin
        w_sign      = ~i_unsigned & w_lane[7];
        o_load_data = {{24{w_sign}}, w_lane[7:0]};
      end
      SZ_HALF: begin
        w_sign      = ~i_unsigned & w_lane[15];
        o_load_data = {{16{w_sign}}, w_lane[15:0]};
      end
      SZ_WORD: o_load_data = i_old_word;
      default: o_load_data = '0;
    endcase
  end

  // Store path: replace only the addressed lane of the old word
  always_comb begin
    o_merged_word = (i_old_word & ~(w_mask << w_shift))
                  | ((i_store_data & w_mask) << w_shift);
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a word-addressed
// memory with combinational read data. Sub-word stores are done as
// read-modify-write (ACCESS reads, WRITE writes). All outputs except
// req_ready are registered.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests are rejected with resp_err instead of being aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // lane logic is built for 32-bit words only
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_addr_lo;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_req_err;
  logic [ADDR_W-1:0] w_word_index;
  logic [DATA_W-1:0] w_load_data;
  logic [DATA_W-1:0] w_merged_word;

  assign w_word_index     = {2'b00, req_addr[ADDR_W-1:2]};
  assign req_ready        = (r_state == ST_IDLE) && rst_n;
  assign resp_valid       = r_resp_valid;
  assign resp_err         = r_resp_err;
  assign resp_rdata       = r_resp_rdata;
  assign mem_write_enable = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_write_data   = r_mem_wdata;

  // Classify the incoming request as rejected before it is accepted
  always_comb begin
    w_req_err = (req_size == SZ_RSVD);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == SZ_HALF) && req_addr[0])
      w_req_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
      w_req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .i_size        (r_size),
    .i_unsigned    (r_uns),
    .i_addr_lo     (r_addr_lo),
    .i_old_word    (mem_read_data),
    .i_store_data  (r_wdata),
    .o_load_data   (w_load_data),
    .o_merged_word (w_merged_word)
  );

  // Request sequencer; memory and response outputs are set up one edge
  // ahead so they are valid for the whole state that owns them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_uns        <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_uns      <= req_unsigned;
            r_addr_lo  <= req_addr[1:0];
            r_wdata    <= req_wdata;
            r_err      <= w_req_err;
            r_mem_addr <= w_word_index;
            // A word store writes straight through during ACCESS
            if (req_we && (req_size == SZ_WORD) && !w_req_err) begin
              r_mem_we    <= 1'b1;
              r_mem_wdata <= req_wdata;
            end
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (!r_err && r_we && (r_size != SZ_WORD)) begin
            // Sub-word store: old word is on mem_read_data now; keep the
            // address and write back the spliced word in WRITE
            r_mem_we    <= 1'b1;
            r_mem_wdata <= w_merged_word;
            r_state     <= ST_WRITE;
          end else begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= r_err;
            r_resp_rdata <= (!r_err && !r_we) ? w_load_data : '0;
            r_state      <= ST_RESP;
          end
        end
        ST_WRITE: begin
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a 1024-word behavioural
// memory. The driver pushes expected responses into a queue; a monitor
// compares every presented response against the queue head.
module tb_load_store_unit;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_resp   = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t exp_q[$];
  bit   front_seen = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: combinational read, write on rising edge, bench preload port
  assign mem_read_data = mem[mem_addr[9:0]];
  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[9:0]] <= mem_write_data;
    else if (pl_en)       mem[pl_idx] <= pl_data;
  end

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: compare every presented response with the queue head
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_resp: rdata 0x%08h err %0b with nothing expected", resp_rdata, resp_err);
      end else begin
        if (!front_seen) begin
          chk("resp_latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          front_seen = 1'b1;
        end
        chk("resp_rdata", resp_rdata, exp_q[0].rdata);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_q[0].err});
        if (resp_ready) begin
          void'(exp_q.pop_front());
          front_seen = 1'b0;
          n_resp++;
          $display("resp #%0d rdata=0x%08h err=%0b", n_resp, resp_rdata, resp_err);
        end
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one request, check memory-side activity, wait for its response
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic [31:0] exp_wr);
    int  prev;
    int  budget;
    bit  sub_wr;
    bit  word_wr;
    exp_t e;
    prev    = n_resp;
    sub_wr  = we && !exp_err && (size != W);
    word_wr = we && !exp_err && (size == W);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size;
    req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    budget = 0;
    while (!req_ready && budget < 20) begin @(negedge clk); budget++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    e.rdata = exp_rdata; e.err = exp_err; e.lat = sub_wr ? 3 : 2; e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("access_mem_addr", mem_addr, {2'b00, addr[31:2]});
    chk("access_mem_we", {31'b0, mem_write_enable}, {31'b0, word_wr});
    if (word_wr) chk("access_wdata", mem_write_data, exp_wr);
    if (sub_wr) begin
      @(negedge clk);
      chk("write_mem_we", {31'b0, mem_write_enable}, 32'd1);
      chk("write_wdata", mem_write_data, exp_wr);
    end
    budget = 0;
    while (n_resp == prev && budget < 30) begin @(negedge clk); budget++; end
    if (n_resp == prev) chk("resp_timeout", 32'(n_resp - prev), 32'd1);
    $display("req we=%0b size=%0d uns=%0b addr=0x%08h wdata=0x%08h done", we, size, uns, addr, wdata);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Word store then word load
    issue(1'b1, W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 32'hDEADBEEF);
    chk("mem_after_word_store", mem[10'h040], 32'hDEADBEEF);
    issue(1'b0, W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);

    // Byte store read-modify-write, then byte loads
    preload(10'h040, 32'h11223344);
    issue(1'b1, B, 1'b0, 32'h103, 32'h000000AA, 32'h0, 1'b0, 32'hAA223344);
    chk("mem_after_byte_store", mem[10'h040], 32'hAA223344);
    issue(1'b0, B, 1'b0, 32'h103, 32'h0, 32'hFFFFFFAA, 1'b0, 32'h0);
    issue(1'b0, B, 1'b1, 32'h103, 32'h0, 32'h000000AA, 1'b0, 32'h0);
    issue(1'b0, B, 1'b0, 32'h101, 32'h0, 32'h00000033, 1'b0, 32'h0);

    // Half loads, including the misaligned case
    preload(10'h040, 32'h80011234);
    issue(1'b0, H, 1'b0, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, H, 1'b1, 32'h101, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b0, W, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, H, 1'b0, 32'h103, 32'h5555, 32'h0, 1'b1, 32'h0);
    chk("mem_after_misaligned_store", mem[10'h040], 32'h80011234);
`else
    issue(1'b0, H, 1'b1, 32'h101, 32'h0, 32'h00001234, 1'b0, 32'h0);
    issue(1'b0, W, 1'b0, 32'h102, 32'h0, 32'h80011234, 1'b0, 32'h0);
`endif

    // Half store into the upper lane, read back both extensions
    issue(1'b1, H, 1'b0, 32'h102, 32'h1234BEEF, 32'h0, 1'b0, 32'hBEEF1234);
    chk("mem_after_half_store", mem[10'h040], 32'hBEEF1234);
    issue(1'b0, H, 1'b1, 32'h102, 32'h0, 32'h0000BEEF, 1'b0, 32'h0);
    issue(1'b0, H, 1'b0, 32'h102, 32'h0, 32'hFFFFBEEF, 1'b0, 32'h0);

    // Reserved size is always rejected and never writes
    issue(1'b0, R, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 32'h0);
    issue(1'b1, R, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0);
    chk("mem_after_rsvd_store", mem[10'h040], 32'hBEEF1234);

    // High address aliases onto the same memory word
    issue(1'b0, W, 1'b0, 32'h1100, 32'h0, 32'hBEEF1234, 1'b0, 32'h0);

    // Response back-pressure: outputs hold and no new request is accepted
    resp_ready = 1'b0;
    fork
      issue(1'b0, W, 1'b0, 32'h100, 32'h0, 32'hBEEF1234, 1'b0, 32'h0);
      begin
        for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
          chk("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
      end
    join

    // Reset during ACCESS of a byte store: no write, no response
    preload(10'h080, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = B; req_unsigned = 1'b0;
    req_addr = 32'h200; req_wdata = 32'h00000011;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    #1;
    chk("rstmid_access_addr", mem_addr, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_mem_we", {31'b0, mem_write_enable}, 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    chk("rstmid_mem_wdata", mem_write_data, 32'd0);
    chk("rstmid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_resp_rdata", resp_rdata, 32'd0);
    chk("rstmid_req_ready", {31'b0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_mem_unchanged", mem[10'h080], 32'h55667788);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_req_ready_back", {31'b0, req_ready}, 32'd1);
    issue(1'b0, W, 1'b0, 32'h200, 32'h0, 32'h55667788, 1'b0, 32'h0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the core's execute stage and the word-addressed data `memory`. It accepts byte-addressed load/store requests of byte, half-word or word size over a valid/ready handshake and drives the memory's `write_enable`/`addr`/`write_data` inputs. It consumes the memory's combinational `read_data`, performs sub-word stores as read-modify-write, and returns sign- or zero-extended load data on a response handshake.

## Interface
- `ADDR_W`, 32, byte address width of core requests and memory address bus
- `DATA_W`, 32, data width; fixed at 32; other values unsupported
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  core request present
- `req_ready`  out  1  LSU can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data, right-aligned
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  core takes response
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors
- `resp_err`  out  1  request rejected (reserved size or misaligned)
- `mem_write_enable`  out  1  to memory `write_enable`
- `mem_addr`  out  ADDR_W  word index, `{2'b00, addr[ADDR_W-1:2]}`
- `mem_write_data`  out  DATA_W  to memory `write_data`
- `mem_read_data`  in  DATA_W  from memory `read_data`, combinational

## Operation
- States: IDLE, ACCESS, WRITE, RESP. `req_ready` = (state == IDLE) && `rst_n`.
- IDLE: on `req_valid && req_ready`, register all req fields, go to ACCESS.
- ACCESS: drive `mem_addr` from registered address.
  - Error request: no memory write; `resp_err`=1, rdata 0; go to RESP.
  - Load: extract lane (byte at `addr[1:0]*8`, half at `addr[1]*16`), extend per `req_unsigned`, register; go to RESP.
  - Word store: `mem_write_enable`=1, data = `req_wdata`; go to RESP.
  - Byte/half store: register `mem_read_data` as old word; go to WRITE.
- WRITE: `mem_write_enable`=1, `mem_write_data` = old word with addressed lane replaced by low 8/16 bits of `req_wdata`; go to RESP.
- RESP: `resp_valid`=1, outputs held stable until `resp_ready`; then go to IDLE.
- Outside ACCESS/WRITE: `mem_write_enable`=0, `mem_addr`=0, `mem_write_data`=0.
- Addresses above 4 KiB alias in memory (only index bits [9:0] used); the LSU does not check range.
- Reserved size 11 always gives an error.

## Timing
- Reset: state IDLE; `resp_valid`, `resp_err`, `resp_rdata`, `mem_*` outputs all 0; `req_ready` 0 while `rst_n` low, 1 after.
- Request accepted in cycle 0. Load/word store/error: `resp_valid` in cycle 2. Byte/half store: `resp_valid` in cycle 3.
- Memory write commits on the rising edge ending ACCESS (word) or WRITE (sub-word).
- Throughput: with `resp_ready` tied 1, one request per 3 cycles (4 for sub-word stores). `req_ready` re-asserts the cycle after the response handshake.
- Reset mid-operation: immediate return to IDLE and `mem_write_enable` drops asynchronously. A sub-word store reset before WRITE leaves memory unchanged. No response is produced.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half with `addr[0]`=1 or word with `addr[1:0]`≠0 is an error, with no memory access.
- Undefined: misaligned low bits are ignored. A half uses lane `addr[1]`; a word uses the full word. No error is raised except for size 11.

## Structure
- `lsu_pkg`: size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), state enum, `LANE_*` shift constants.
- Sub-module `lsu_align`: combinational lane extract and extend for loads, and lane merge for stores. The FSM and registers stay in `load_store_unit`.

## Test plan
- Word store 0xDEADBEEF to 0x100, then word load at 0x100 -> `mem_addr`=0x40 both times; `resp_rdata`=0xDEADBEEF; load response in cycle 2.
- Byte store 0xAA to 0x103 over word 0x11223344 -> WRITE writes 0xAA223344; response in cycle 3.
- Byte load at 0x103 with signed then unsigned -> 0xFFFFFFAA, then 0x000000AA.
- Half load at 0x102 from 0x8001_1234 (signed) -> 0xFFFF8001.
- Half load at 0x101 -> with macro: `resp_err`=1, rdata 0, no write. Without macro: lane 0 is read, giving 0x00001234 (unsigned).
- `resp_ready` held 0 for 5 cycles -> `resp_valid`/rdata stable and `req_ready`=0. Then assert `rst_n`=0 during ACCESS of a byte store -> memory unchanged and outputs 0.
